// File: rtl/johnson_counter_param.sv
// Parametrised Johnson (twisted-ring) counter with enable, direction, load, phase index and terminal count.
// Define JCNT_SELF_CORRECT_EN to add the err flag and illegal-state recovery to all ones.
module johnson_counter_param #(
  parameter int WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            dir,
  input  logic                            load,
  input  logic [WIDTH-1:0]                load_val,
  output logic [WIDTH-1:0]                out,
  output logic [$clog2(2*WIDTH)-1:0]      phase,
  output logic                            tc,
  output logic                            err
);

  localparam int PW = $clog2(2*WIDTH);
  localparam logic [WIDTH-1:0] LAST_PAT = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] step_nxt;
  logic [WIDTH-1:0] pat;
  logic [PW-1:0]    phase_c;

  always_comb begin
    if (dir) step_nxt = {out[WIDTH-2:0], ~out[WIDTH-1]};
    else     step_nxt = {~out[0], out[WIDTH-1:1]};
  end

  // Exact match against each legal pattern; no match (illegal) leaves phase at 0.
  always_comb begin
    phase_c = '0;
    pat     = '0;
    for (int unsigned p = 0; p < 2*WIDTH; p++) begin
      pat = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (p <= WIDTH) pat[i] = (i < WIDTH - p);
        else            pat[i] = (i >= 2*WIDTH - p);
      end
      if (out == pat) phase_c = PW'(p);
    end
  end

  assign phase = phase_c;

  // Comparing against the exact end patterns already implies legality.
  assign tc = en & ~load & (dir ? (out == '1) : (out == LAST_PAT));

`ifdef JCNT_SELF_CORRECT_EN
  logic [WIDTH-2:0] trans;
  logic             legal;

  assign trans = out[WIDTH-1:1] ^ out[WIDTH-2:0];
  assign legal = ((trans & (trans - 1'b1)) == '0);
  assign err   = ~legal;
`else
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out <= '1;
    else if (load)
      out <= load_val;
`ifdef JCNT_SELF_CORRECT_EN
    else if (!legal)
      out <= '1;
`endif
    else if (en)
      out <= step_nxt;
  end

endmodule

// File: tb/tb_johnson_counter_param.sv
// Scoreboard bench for johnson_counter_param: WIDTH=4 and WIDTH=5 instances, directed vectors.
module tb_johnson_counter_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en4, dir4, load4;
  logic [3:0] lv4;
  logic [3:0] out4;
  logic [2:0] phase4;
  logic       tc4, err4;
  logic       en5, dir5, load5;
  logic [4:0] lv5;
  logic [4:0] out5;
  logic [3:0] phase5;
  logic       tc5, err5;

  johnson_counter_param #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .en(en4), .dir(dir4), .load(load4), .load_val(lv4),
    .out(out4), .phase(phase4), .tc(tc4), .err(err4)
  );

  johnson_counter_param #(.WIDTH(5)) u5 (
    .clk(clk), .rst(rst), .en(en5), .dir(dir5), .load(load5), .load_val(lv5),
    .out(out5), .phase(phase5), .tc(tc5), .err(err5)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    string       nm;
    logic [15:0] out;
    logic [4:0]  phase;
    logic        tc;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef JCNT_SELF_CORRECT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  task automatic push(input int id, input string nm, input logic [15:0] xo,
                      input int xp, input logic xtc, input logic xerr);
    exp_t x;
    x.id = id; x.nm = nm; x.out = xo; x.phase = 5'(xp); x.tc = xtc; x.err = xerr;
    q.push_back(x);
  endtask

  // One cycle: drive inputs after the edge, expect the pre-step outputs this cycle.
  task automatic vec(input int id, input string nm, input logic e, input logic d,
                     input logic l, input logic [15:0] lv, input logic [15:0] xo,
                     input int xp, input logic xtc, input logic xerr);
    @(posedge clk);
    #1;
    if (id == 0) begin
      en4 = e; dir4 = d; load4 = l; lv4 = lv[3:0];
    end else begin
      en5 = e; dir5 = d; load5 = l; lv5 = lv[4:0];
    end
    push(id, nm, xo, xp, xtc, xerr);
  endtask

  exp_t        mx;
  logic [15:0] a_out;
  logic [4:0]  a_ph;
  logic        a_tc, a_err;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mx = q.pop_front();
      if (mx.id == 0) begin
        a_out = {12'b0, out4}; a_ph = {2'b0, phase4}; a_tc = tc4; a_err = err4;
      end else begin
        a_out = {11'b0, out5}; a_ph = {1'b0, phase5}; a_tc = tc5; a_err = err5;
      end
      n_chk++;
      if (a_out !== mx.out || a_ph !== mx.phase || a_tc !== mx.tc || a_err !== mx.err) begin
        n_fail++;
        $display("FAIL %s: got out=%h phase=%0d tc=%b err=%b, want out=%h phase=%0d tc=%b err=%b",
                 mx.nm, a_out, a_ph, a_tc, a_err, mx.out, mx.phase, mx.tc, mx.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    en4 = 0; dir4 = 0; load4 = 0; lv4 = '0;
    en5 = 0; dir5 = 0; load5 = 0; lv5 = '0;

    vec(0, "rst_hold4", 0, 0, 0, 16'h0, 16'hF, 0, 0, 0);
    vec(1, "rst_hold5", 0, 0, 0, 16'h0, 16'h1F, 0, 0, 0);
    rst = 1'b0;

    vec(0, "pre0", 1, 0, 0, 16'h0, 16'hF, 0, 0, 0);
    vec(0, "pre1", 1, 0, 0, 16'h0, 16'h7, 1, 0, 0);
    vec(0, "pre2", 1, 0, 0, 16'h0, 16'h3, 2, 0, 0);
    // out becomes 0001 here; reset asserted between edges must act before the next edge
    @(posedge clk);
    #3;
    rst = 1'b1;
    en4 = 1'b0;
    push(0, "rst_async", 16'hF, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    vec(0, "fwd_p0", 1, 0, 0, 16'h0, 16'hF, 0, 0, 0);
    vec(0, "fwd_p1", 1, 0, 0, 16'h0, 16'h7, 1, 0, 0);
    vec(0, "fwd_p2", 1, 0, 0, 16'h0, 16'h3, 2, 0, 0);
    vec(0, "fwd_p3", 1, 0, 0, 16'h0, 16'h1, 3, 0, 0);
    vec(0, "fwd_p4", 1, 0, 0, 16'h0, 16'h0, 4, 0, 0);
    vec(0, "fwd_p5", 1, 0, 0, 16'h0, 16'h8, 5, 0, 0);
    vec(0, "fwd_p6", 1, 0, 0, 16'h0, 16'hC, 6, 0, 0);
    vec(0, "fwd_p7_tc", 1, 0, 0, 16'h0, 16'hE, 7, 1, 0);
    vec(0, "fwd_wrap", 1, 0, 0, 16'h0, 16'hF, 0, 0, 0);
    vec(0, "fwd_p1b", 1, 0, 0, 16'h0, 16'h7, 1, 0, 0);

    vec(0, "rev_p2", 1, 1, 0, 16'h0, 16'h3, 2, 0, 0);
    vec(0, "rev_p1", 1, 1, 0, 16'h0, 16'h7, 1, 0, 0);
    vec(0, "rev_p0_tc", 1, 1, 0, 16'h0, 16'hF, 0, 1, 0);
    vec(0, "rev_p7_flip", 1, 0, 0, 16'h0, 16'hE, 7, 1, 0);

    vec(0, "hold0", 0, 0, 0, 16'h0, 16'hF, 0, 0, 0);
    vec(0, "hold1", 0, 0, 0, 16'h0, 16'hF, 0, 0, 0);
    vec(0, "hold2_dir1", 0, 1, 0, 16'h0, 16'hF, 0, 0, 0);
    vec(0, "hold3", 0, 0, 0, 16'h0, 16'hF, 0, 0, 0);
    vec(0, "hold4", 0, 0, 0, 16'h0, 16'hF, 0, 0, 0);

    vec(0, "load_en_tc_mask", 1, 1, 1, 16'h8, 16'hF, 0, 0, 0);
    vec(0, "load_p5", 1, 0, 0, 16'h0, 16'h8, 5, 0, 0);
    vec(0, "step_p6", 0, 0, 0, 16'h0, 16'hC, 6, 0, 0);
    vec(0, "load_e_noen", 0, 0, 1, 16'hE, 16'hC, 6, 0, 0);
    vec(0, "p7_en0_notc", 0, 0, 0, 16'h0, 16'hE, 7, 0, 0);
    vec(0, "p7_en1_tc", 1, 0, 0, 16'h0, 16'hE, 7, 1, 0);
    vec(0, "wrap_hold", 0, 0, 0, 16'h0, 16'hF, 0, 0, 0);

    vec(0, "ill_load", 0, 0, 1, 16'h5, 16'hF, 0, 0, 0);
    vec(0, "ill_present", 0, 0, 0, 16'h0, 16'h5, 0, 0, SC);
    if (SC) begin
      vec(0, "ill_recovered", 1, 0, 0, 16'h0, 16'hF, 0, 0, 0);
      vec(0, "ill_after_fwd", 1, 1, 0, 16'h0, 16'h7, 1, 0, 0);
      vec(0, "ill_after_rev", 0, 0, 0, 16'h0, 16'hF, 0, 0, 0);
    end else begin
      vec(0, "ill_persist", 1, 0, 0, 16'h0, 16'h5, 0, 0, 0);
      vec(0, "ill_fwd_shift", 1, 1, 0, 16'h0, 16'h2, 0, 0, 0);
      vec(0, "ill_rev_shift", 0, 0, 0, 16'h0, 16'h5, 0, 0, 0);
    end

    vec(1, "w5_p0", 1, 0, 0, 16'h0, 16'h1F, 0, 0, 0);
    vec(1, "w5_p1", 1, 0, 0, 16'h0, 16'h0F, 1, 0, 0);
    vec(1, "w5_p2", 1, 0, 0, 16'h0, 16'h07, 2, 0, 0);
    vec(1, "w5_p3", 1, 0, 0, 16'h0, 16'h03, 3, 0, 0);
    vec(1, "w5_p4", 1, 0, 0, 16'h0, 16'h01, 4, 0, 0);
    vec(1, "w5_p5", 1, 0, 0, 16'h0, 16'h00, 5, 0, 0);
    vec(1, "w5_p6", 1, 0, 0, 16'h0, 16'h10, 6, 0, 0);
    vec(1, "w5_p7", 1, 0, 0, 16'h0, 16'h18, 7, 0, 0);
    vec(1, "w5_p8", 1, 0, 0, 16'h0, 16'h1C, 8, 0, 0);
    vec(1, "w5_p9_tc", 1, 0, 0, 16'h0, 16'h1E, 9, 1, 0);
    vec(1, "w5_wrap", 0, 0, 0, 16'h0, 16'h1F, 0, 0, 0);

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/johnson_counter_param.md
# johnson_counter_param

- Parametrised Johnson (twisted-ring) counter: WIDTH-bit register, 2·WIDTH-state sequence.
- Adds over the fixed 4-bit counter:
  - run enable
  - direction select (forward/reverse)
  - raw parallel load
  - binary phase index output
  - terminal-count pulse
  - optional illegal-state self-correction
- Serves as a phase generator / sequencer for lab timing blocks. Runs in the single system clock domain.

## Interface

Parameters:
- WIDTH, 4: counter register width; legal range 2..16; sequence length 2·WIDTH.
- PW (localparam) = $clog2(2·WIDTH): phase index width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high; one clock; asynchronous active-high reset.
- en  input  1  advance one state per clock when high.
- dir  input  1  0 = forward, 1 = reverse.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  WIDTH  raw pattern loaded on load; may be illegal.
- out  output  WIDTH  counter register.
- phase  output  PW  binary index of the current state, 0..2·WIDTH-1.
- tc  output  1  terminal count: the next enabled step wraps.
- err  output  1  out holds an illegal pattern (only when the macro is defined).

## Operation

State sequence:
- Phase 0 is all ones.
- Forward step: out_next = {~out[0], out[WIDTH-1:1]}.
- Reverse step: out_next = {out[WIDTH-2:0], ~out[WIDTH-1]}.
- WIDTH=4 forward order: 1111, 0111, 0011, 0001, 0000, 1000, 1100, 1110, then back to 1111.

Phase decode (combinational from out):
- p in 0..WIDTH: top p bits 0, remaining bits 1.
- p in WIDTH+1..2·WIDTH-1: top p-WIDTH bits 1, remaining bits 0.
- Illegal pattern: phase = 0.

Legality:
- out is legal iff adjacent-bit transitions (out[i] != out[i+1], i = 0..WIDTH-2) number ≤ 1.
- Exactly 2·WIDTH patterns are legal.

tc:
- tc = en & ~load & (dir ? phase == 0 : phase == 2·WIDTH-1) & legal.

Update priority at each posedge (highest first):
1. rst
2. load
3. illegal recovery (macro only)
4. en step
5. hold

Rules:
- dir is sampled each cycle; changing it mid-sequence reverses from the current state without a skipped or repeated state.
- load with en high: load wins; the step is dropped.

## Timing

- Reset (asynchronous assert, held while high): out = all ones, phase = 0, tc = 0, err = 0.
- Release: synchronous use; first step at the first posedge with rst low and en high.
- Step latency: one clock; out reflects the step after the edge.
- phase, tc, err: combinational from out/en/dir/load, valid in the same cycle; no added latency.
- Wrap: forward from phase 2·WIDTH-1 → 0; reverse from 0 → 2·WIDTH-1. tc is high in the cycle before the wrapping edge.
- rst mid-sequence: immediate return to all ones regardless of clk; any in-flight load is discarded.

## Configuration

JCNT_SELF_CORRECT_EN:
- Defined:
  - err = ~legal.
  - At the next posedge with no rst and no load, an illegal out is replaced by all ones (phase 0), regardless of en.
  - err is therefore high for exactly one cycle per illegal entry.
- Undefined:
  - err tied to 0.
  - Illegal patterns shift with the normal step equations and persist indefinitely.
  - Legality logic is not synthesised.

## Test plan

- Reset: assert rst mid-count at a non-edge time → out = 1111 immediately; phase = 0; hold en high 8 clocks → out sequence 0111, 0011, 0001, 0000, 1000, 1100, 1110, 1111; tc high only while out = 1110.
- Reverse: from 0011 (phase 2) set dir = 1 → 0111, 1111, 1110; tc high while out = 1111 and dir = 1; dir flips back at 1110 → 1111.
- Hold/priority: en = 0 for 5 clocks → out unchanged; load = 1, load_val = 1000 with en = 1 → out = 1000, phase = 5, no step; next en edge → 1100.
- WIDTH=5: 10 enabled clocks return to 11111; phase steps 0..9 in order; phase = 5 at 00000.
- Macro defined: load 0101 → err = 1, phase = 0 that cycle; next edge with en = 0 → out = 1111, err = 0.
- Macro undefined: load 0101 → err = 0; next enabled forward edge → out = 0010; no recovery.
